bit_index_writer: RTL

- Upstream stage that produces the 8-bit flag vector consumed by the case-decode bit-set logic in the `main` test module.
- Accepts indexed single-bit write requests over a valid/ready handshake and applies them to an internal WIDTH-bit vector.
- Detects out-of-range indices (idx >= WIDTH), drops them, and counts them; it must never corrupt the vector or fault on them.
- Drains the vector on command, emitting set-bit indices lowest-first over a second valid/ready handshake and clearing each bit as it is consumed.

---
 rtl/bit_index_writer.sv | 74 +++++++
 1 files changed

// File: rtl/bit_index_writer.sv
// bit_index_writer: indexed single-bit writer with out-of-range counting and lowest-first drain
// Ports: clk/rst (sync, active-high); req_valid/req_ready/req_idx/req_val write handshake;
//        clr clears vec and aborts drain; drain_start begins drain;
//        drain_valid/drain_ready/drain_idx drain handshake; vec current vector;
//        busy high in DRAIN; oor_sticky/oor_count out-of-range tracking.
module bit_index_writer #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_idx,
    input  logic             req_val,
    input  logic             clr,
    input  logic             drain_start,
    output logic             drain_valid,
    input  logic             drain_ready,
    output logic [IDX_W-1:0] drain_idx,
    output logic [WIDTH-1:0] vec,
    output logic             busy,
    output logic             oor_sticky,
    output logic [ERR_W-1:0] oor_count
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;
    logic [0:0]       state;
    logic             acc, in_range, pop;
    logic [WIDTH-1:0] wr_mask, vec_wr, low_mask, vec_pop;
    logic [IDX_W-1:0] low;
    assign req_ready   = state == IDLE && !clr;
    assign busy        = state == DRAIN;
    assign drain_valid = busy && vec != '0;
    assign acc         = req_valid && req_ready;
    // full-width compare so indices past WIDTH never alias onto low bits
    assign in_range    = 32'(req_idx) < 32'(WIDTH);
    assign wr_mask     = in_range ? WIDTH'(1) << req_idx : '0;
    assign vec_wr      = acc ? (req_val ? vec | wr_mask : vec & ~wr_mask) : vec;
    // two's-complement trick isolates the lowest set bit
    assign low_mask    = vec & (~vec + WIDTH'(1));
    assign vec_pop     = vec & ~low_mask;
    assign pop         = drain_valid && drain_ready;
    assign drain_idx   = drain_valid ? low : '0;
    always_comb begin
        low = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (vec[i]) low = IDX_W'(i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            vec        <= '0;
            state      <= IDLE;
            oor_sticky <= 1'b0;
            oor_count  <= '0;
        end else begin
            if (acc && !in_range) begin
                oor_sticky <= 1'b1;
                oor_count  <= oor_count != '1 ? oor_count + ERR_W'(1) : oor_count;
            end
            if (clr) begin
                vec   <= '0;
                state <= IDLE;
            end else if (state == IDLE) begin
                vec   <= vec_wr;
                state <= drain_start && vec_wr != '0 ? DRAIN : IDLE;
            end else if (pop) begin
                vec   <= vec_pop;
                state <= vec_pop == '0 ? IDLE : DRAIN;
            end
        end
    end
endmodule
